// File: rtl/move_cmd_sequencer_if.sv
// Handshake and status bundle between the move sequencer and its neighbours
// (button debounce inputs, external direction decoder, 2048 game core).
interface move_cmd_sequencer_if;
    logic [3:0] btn_dir;
    logic [3:0] ext_dir;
    logic       ext_valid;
    logic       ext_ready;
    logic [1:0] game_state;
    logic [3:0] cmd_dir;
    logic       cmd_valid;
    logic       cmd_ack;
    logic       drop_pulse;

    // Side that supplies directions and acknowledges commands.
    modport master (
        output btn_dir, ext_dir, ext_valid, game_state, cmd_ack,
        input  ext_ready, cmd_dir, cmd_valid, drop_pulse
    );

    // The sequencer itself.
    modport slave (
        input  btn_dir, ext_dir, ext_valid, game_state, cmd_ack,
        output ext_ready, cmd_dir, cmd_valid, drop_pulse
    );
endinterface

// File: rtl/move_cmd_sequencer.sv
// Merges debounced button presses and a queued external direction stream into
// one-hot move commands, held under valid/ack until the game core accepts them.
module move_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 2,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    move_cmd_sequencer_if.slave  bus
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic playing;
    assign playing = (bus.game_state == 2'b01);

    // ---------------- debounce and press detect ----------------
    logic [3:0]      btn_prev;
    logic [3:0]      btn_stable;
    logic [DB_W-1:0] db_cnt;
    logic            stable_load;
    logic            press;

    assign stable_load = (bus.btn_dir == btn_prev) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    // A press must start from a released (0000) stable level, which also
    // provides the lockout: nothing fires again until the button is let go.
    assign press = stable_load && (btn_stable == 4'b0000) && is_onehot(bus.btn_dir);

    // Count identical consecutive samples; adopt the level once it has held long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev   <= '0;
            btn_stable <= '0;
            db_cnt     <= '0;
        end else begin
            // NOTE: clocked state uses <= so every register samples pre-edge values.
            btn_prev <= bus.btn_dir;
            if (bus.btn_dir != btn_prev) begin
                db_cnt <= '0;
            end else if (stable_load) begin
                btn_stable <= bus.btn_dir;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ---------------- external queue ----------------
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic             full;
    logic             xfer;
    logic             push;
    logic             ext_drop;
    logic             take_pending;
    logic             take_queue;

    assign full          = (q_count == CNT_W'(FIFO_DEPTH));
    assign bus.ext_ready = ~full & ~rst;
    assign xfer          = bus.ext_valid & ~full;
    assign push          = xfer & playing & is_onehot(bus.ext_dir);
    assign ext_drop      = xfer & playing & ~is_onehot(bus.ext_dir);

    // Queue storage: written on push only.
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; occupancy is tracked by q_count, so stale entries are never read.
        if (push) fifo_mem[wr_ptr] <= bus.ext_dir;
    end

    // Queue pointers and occupancy; leaving play flushes the queue.
    always_ff @(posedge clk) begin
        if (rst || !playing) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push)       wr_ptr <= ptr_inc(wr_ptr);
            if (take_queue) rd_ptr <= ptr_inc(rd_ptr);
            q_count <= q_count + CNT_W'(push) - CNT_W'(take_queue);
        end
    end

    // ---------------- pending button slot ----------------
    logic       pending_q;
    logic [3:0] pending_dir;
    logic       btn_drop;

    assign btn_drop = press & pending_q & playing;

    // One-deep holding slot for a button press; a press into a full slot is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            pending_dir <= '0;
        end else if (!playing || take_pending) begin
            pending_q <= 1'b0;
        end else if (press && !pending_q) begin
            pending_q   <= 1'b1;
            pending_dir <= bus.btn_dir;
        end
    end

    // ---------------- command FSM ----------------
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cmd_dir_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             drop_q;

    // Next state and source selection; buttons win over the queue head.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d      = state_q;
        take_pending = 1'b0;
        take_queue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (playing && pending_q) begin
                    state_d      = ISSUE;
                    take_pending = 1'b1;
                end else if (playing && (q_count != '0)) begin
                    state_d    = ISSUE;
                    take_queue = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.cmd_ack) state_d = (HOLDOFF_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(HOLDOFF_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!playing) state_d = IDLE;
    end

    // State register, latched command and hold-off counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_dir_q <= '0;
            gap_cnt   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_pending)    cmd_dir_q <= pending_dir;
            else if (take_queue) cmd_dir_q <= fifo_mem[rd_ptr];
            gap_cnt <= (state_q == GAP && state_d == GAP) ? gap_cnt + 1'b1 : '0;
            drop_q  <= btn_drop | ext_drop;
        end
    end

    assign bus.cmd_valid  = (state_q == ISSUE);
    assign bus.cmd_dir    = bus.cmd_valid ? cmd_dir_q : 4'b0000;
    assign bus.drop_pulse = drop_q;
endmodule

// File: tb/tb_move_cmd_sequencer.sv
// Self-checking bench for move_cmd_sequencer: directed sequences, a vector
// table for the queue/hold-off behaviour, and randomized traffic compared
// cycle by cycle against a transaction-level reference model.
module tb_move_cmd_sequencer;
    localparam int DEB   = 16;
    localparam int DEPTH = 2;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_cmd_sequencer_if bus();

    move_cmd_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Button debouncing as a run length of identical samples; the queue is a
    // real SV queue; hold-off is an "earliest edge an issue may happen" stamp.
    int         m_edge = 0;
    logic [3:0] m_last = '0;
    int         m_run = 0;
    logic [3:0] m_stable = '0;
    logic [3:0] m_pend = '0;
    logic [3:0] m_q[$];
    logic [3:0] m_cur = '0;
    int         m_earliest = 0;
    logic       m_drop = 1'b0;

    function automatic logic onehot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic model_edge();
        logic       playing;
        logic       issue;
        logic       pend_full;
        logic       press;
        logic       xfer;
        logic [3:0] win;
        m_edge++;
        if (rst) begin
            m_last = '0; m_run = 0; m_stable = '0; m_pend = '0;
            m_q.delete(); m_cur = '0; m_earliest = m_edge + 1; m_drop = 1'b0;
            return;
        end
        playing   = (bus.game_state == 2'b01);
        issue     = playing && (m_cur == 0) && (m_edge >= m_earliest) && (m_pend != 0 || m_q.size() != 0);
        win       = (m_pend != 0) ? m_pend : ((m_q.size() != 0) ? m_q[0] : 4'b0000);
        pend_full = (m_pend != 0);
        xfer      = bus.ext_valid && (m_q.size() < DEPTH);
        press     = 1'b0;
        if (bus.btn_dir == m_last) begin
            if (m_run >= DEB - 1 && bus.btn_dir != m_stable) begin
                press    = (m_stable == 4'b0000) && onehot(bus.btn_dir);
                m_stable = bus.btn_dir;
            end
            m_run++;
        end else begin
            m_run = 0;
        end
        m_last = bus.btn_dir;
        m_drop = 1'b0;
        if (!playing) begin
            m_pend = '0; m_q.delete(); m_cur = '0; m_earliest = m_edge + 1;
        end else begin
            if (m_cur != 0 && bus.cmd_ack) begin
                m_cur      = '0;
                m_earliest = m_edge + HOLD + 1;
            end
            if (issue) begin
                m_cur = win;
                if (pend_full) m_pend = '0;
                else           void'(m_q.pop_front());
            end
            if (press) begin
                if (pend_full) m_drop = 1'b1;
                else           m_pend = bus.btn_dir;
            end
            if (xfer) begin
                if (onehot(bus.ext_dir)) m_q.push_back(bus.ext_dir);
                else                     m_drop = 1'b1;
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare away from it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_cmd_valid",  32'(bus.cmd_valid),  32'(m_cur != 0));
        check("model_cmd_dir",    32'(bus.cmd_dir),    32'(m_cur));
        check("model_ext_ready",  32'(bus.ext_ready),  32'(!rst && m_q.size() < DEPTH));
        check("model_drop_pulse", 32'(bus.drop_pulse), 32'(m_drop));
    endtask

    task automatic run(input int n, output int valids, output int drops);
        valids = 0;
        drops  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.cmd_valid)  valids++;
            if (bus.drop_pulse) drops++;
        end
    endtask

    task automatic push(input logic [3:0] d);
        bus.ext_valid = 1'b1;
        bus.ext_dir   = d;
        tick();
        bus.ext_valid = 1'b0;
        bus.ext_dir   = 4'b0000;
    endtask

    task automatic ack();
        bus.cmd_ack = 1'b1;
        tick();
        bus.cmd_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!bus.cmd_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, "_seen"}, 32'(bus.cmd_valid), 32'(1));
    endtask

    typedef struct {
        logic       ev;
        logic [3:0] dir;
        logic       ack;
        logic       rdy;
        logic       vld;
        logic [3:0] cdir;
        logic       drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ev, input logic [3:0] dir, input logic ak,
                       input logic rdy, input logic vld, input logic [3:0] cdir, input logic drop);
        vec_t v;
        v = '{ev, dir, ak, rdy, vld, cdir, drop};
        tbl.push_back(v);
    endtask

    initial begin
        int nv;
        int nd;
        int n;

        // Queue fill, refused push, hold-off spacing, invalid direction drop.
        add(1, 4'b0001, 0,  1, 0, 4'b0000, 0);
        add(1, 4'b0010, 0,  1, 1, 4'b0001, 0);
        add(1, 4'b1000, 0,  0, 1, 4'b0001, 0);
        add(1, 4'b0100, 0,  0, 1, 4'b0001, 0);
        add(0, 4'b0000, 1,  0, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0,  0, 0, 4'b0000, 0);
        add(0, 4'b0000, 0,  1, 1, 4'b0010, 0);
        add(0, 4'b0000, 1,  1, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 0,  1, 0, 4'b0000, 0);
        add(0, 4'b0000, 0,  1, 1, 4'b1000, 0);
        add(0, 4'b0000, 1,  1, 0, 4'b0000, 0);
        add(1, 4'b0011, 0,  1, 0, 4'b0000, 1);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 0,  1, 0, 4'b0000, 0);

        rst            = 1'b1;
        bus.btn_dir    = 4'b0000;
        bus.ext_dir    = 4'b0000;
        bus.ext_valid  = 1'b0;
        bus.game_state = 2'b01;
        bus.cmd_ack    = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_cmd_valid", 32'(bus.cmd_valid),  32'(0));
        check("rst_cmd_dir",   32'(bus.cmd_dir),    32'(4'b0000));
        check("rst_ext_ready", 32'(bus.ext_ready),  32'(0));
        check("rst_drop",      32'(bus.drop_pulse), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.ext_ready), 32'(1));

        // Held button: one command after debounce, held until ack, no repeat.
        bus.btn_dir = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_valid && n < 40);
        check("t1_press_latency", 32'(n), 32'(18));
        check("t1_dir", 32'(bus.cmd_dir), 32'(4'b0100));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_dir", 32'(bus.cmd_dir), 32'(4'b0100));
        end
        ack();
        check("t1_valid_after_ack", 32'(bus.cmd_valid), 32'(0));
        run(20, nv, nd);
        check("t1_no_repeat", 32'(nv), 32'(0));
        bus.btn_dir = 4'b0000;
        run(20, nv, nd);

        // Bouncing button never settles.
        nv = 0;
        for (int t = 0; t < 8; t++) begin
            int v;
            int d;
            bus.btn_dir = (t % 2 == 0) ? 4'b0100 : 4'b0000;
            run(8, v, d);
            nv += v;
        end
        check("t2_no_cmd", 32'(nv), 32'(0));
        bus.btn_dir = 4'b0000;
        run(10, nv, nd);

        // Vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            bus.ext_valid = tbl[i].ev;
            bus.ext_dir   = tbl[i].dir;
            bus.cmd_ack   = tbl[i].ack;
            tick();
            check($sformatf("tbl%0d_ready", i), 32'(bus.ext_ready),  32'(tbl[i].rdy));
            check($sformatf("tbl%0d_valid", i), 32'(bus.cmd_valid),  32'(tbl[i].vld));
            check($sformatf("tbl%0d_dir",   i), 32'(bus.cmd_dir),    32'(tbl[i].cdir));
            check($sformatf("tbl%0d_drop",  i), 32'(bus.drop_pulse), 32'(tbl[i].drop));
        end
        bus.ext_valid = 1'b0;
        bus.ext_dir   = 4'b0000;
        bus.cmd_ack   = 1'b0;

        // Button press has priority over a queued entry.
        push(4'b0100);
        push(4'b0001);
        bus.btn_dir = 4'b1000;
        run(20, nv, nd);
        bus.btn_dir = 4'b0000;
        ack();
        wait_valid("t4_first", n);
        check("t4_first_dir", 32'(bus.cmd_dir), 32'(4'b1000));
        check("t4_gap_ok", 32'(n >= HOLD), 32'(1));
        ack();
        wait_valid("t4_second", n);
        check("t4_second_dir", 32'(bus.cmd_dir), 32'(4'b0001));
        ack();
        run(20, nv, nd);

        // Second press while the pending slot is full is dropped.
        push(4'b0100);
        tick();
        bus.btn_dir = 4'b0100;
        run(20, nv, nd);
        bus.btn_dir = 4'b0000;
        run(20, nv, nd);
        bus.btn_dir = 4'b0010;
        run(20, nv, nd);
        check("t5_btn_drop", 32'(nd), 32'(1));
        bus.btn_dir = 4'b0000;
        ack();
        wait_valid("t5_pending", n);
        check("t5_pending_dir", 32'(bus.cmd_dir), 32'(4'b0100));
        ack();
        run(25, nv, nd);
        check("t5_no_extra", 32'(nv), 32'(0));

        // Leaving play during ISSUE flushes everything.
        push(4'b0001);
        push(4'b0010);
        check("t6_issuing", 32'(bus.cmd_valid), 32'(1));
        bus.game_state = 2'b11;
        tick();
        check("t6_valid_off", 32'(bus.cmd_valid), 32'(0));
        check("t6_dir_zero",  32'(bus.cmd_dir),   32'(4'b0000));
        bus.game_state = 2'b01;
        run(20, nv, nd);
        check("t6_no_resume_cmd", 32'(nv), 32'(0));

        // Reset in the middle of a command.
        push(4'b1000);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 32'(bus.cmd_valid), 32'(0));
        check("rst_mid_ready", 32'(bus.ext_ready), 32'(0));
        rst = 1'b0;
        tick();
        check("rst_mid_ready_back", 32'(bus.ext_ready), 32'(1));

        // Ack together with leaving play.
        push(4'b0001);
        push(4'b0010);
        bus.cmd_ack    = 1'b1;
        bus.game_state = 2'b00;
        tick();
        check("ack_leave_valid", 32'(bus.cmd_valid), 32'(0));
        bus.cmd_ack    = 1'b0;
        bus.game_state = 2'b01;
        run(20, nv, nd);
        check("ack_leave_no_cmd", 32'(nv), 32'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 23) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.btn_dir = 4'b0000;
                    3:       bus.btn_dir = 4'($urandom);
                    default: bus.btn_dir = 4'b0001 << $urandom_range(0, 3);
                endcase
            end
            bus.ext_valid  = ($urandom_range(0, 2) == 0);
            bus.ext_dir    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            bus.cmd_ack    = (m_cur != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            bus.game_state = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : 2'b01;
            rst            = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
